branch_predictor: RTL and testbench

- Branch Prediction Unit that drives the control unit's `in_prediction` input and owns misprediction flush.
- Bimodal table of 2-bit saturating counters, indexed by PC; looked up at fetch, trained at branch resolution in execute.
- Detects mispredictions, raises a registered flush pulse and keeps a misprediction counter for performance monitoring.

---
 rtl/branch_predictor.sv | 97 +++++++++
 tb/tb_branch_predictor.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Bimodal branch predictor: a table of 2-bit saturating counters indexed by PC.
// Looked up at fetch (registered, 1-cycle latency), trained at branch
// resolution, and raises a registered flush pulse on every misprediction.
module branch_predictor #(
  parameter int INDEX_BITS = 6,
  parameter int PC_WIDTH   = 64,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 in_clk,
  input  logic                 in_rst,
  input  logic                 in_stall,
  input  logic                 in_lookup_valid,
  input  logic [PC_WIDTH-1:0]  in_lookup_pc,
  output logic                 out_prediction,
  output logic                 out_pred_valid,
  input  logic                 in_update_valid,
  input  logic [PC_WIDTH-1:0]  in_update_pc,
  input  logic                 in_update_taken,
  input  logic                 in_update_predicted,
  output logic                 out_flush,
  output logic [CNT_WIDTH-1:0] out_mispredict_count
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  // Counters live in flops rather than RAM: all of them must clear to
  // weakly-not-taken the instant reset rises.
  logic [1:0] counters [ENTRIES];

  logic [INDEX_BITS-1:0] lookup_idx;
  logic [INDEX_BITS-1:0] update_idx;
  logic [1:0]            update_cur;
  logic [1:0]            update_next;
  logic [1:0]            lookup_counter;
  logic                  mispredict;

  // Word-aligned instructions: the two low PC bits carry no information,
  // and bits above the index alias onto the same counter (no tags).
  assign lookup_idx = in_lookup_pc[INDEX_BITS+1:2];
  assign update_idx = in_update_pc[INDEX_BITS+1:2];
  assign update_cur = counters[update_idx];
  assign mispredict = in_update_valid && (in_update_taken != in_update_predicted);

  // PC bits outside the index field are intentionally ignored.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{in_lookup_pc[PC_WIDTH-1:INDEX_BITS+2], in_lookup_pc[1:0],
                            in_update_pc[PC_WIDTH-1:INDEX_BITS+2], in_update_pc[1:0]};

  // Saturating increment/decrement of the counter being trained.
  always_comb begin
    update_next = update_cur;
    if (in_update_taken) begin
      if (update_cur != 2'b11) update_next = update_cur + 2'b01;
    end else begin
      if (update_cur != 2'b00) update_next = update_cur - 2'b01;
    end
  end

  // Lookup sees the post-update value when it hits the entry being trained.
  always_comb begin
    lookup_counter = counters[lookup_idx];
    if (in_update_valid && (update_idx == lookup_idx)) lookup_counter = update_next;
  end

  // Counter table: trained only on a valid update, regardless of stall.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      for (int i = 0; i < ENTRIES; i++) counters[i] <= 2'b01;
    end else if (in_update_valid) begin
      counters[update_idx] <= update_next;
    end
  end

  // Registered lookup result; a stall freezes it.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      out_prediction <= 1'b0;
      out_pred_valid <= 1'b0;
    end else if (!in_stall) begin
      out_pred_valid <= in_lookup_valid;
      out_prediction <= in_lookup_valid ? lookup_counter[1] : 1'b0;
    end
  end

  // Flush pulse and saturating misprediction counter, both stall-independent.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      out_flush            <= 1'b0;
      out_mispredict_count <= '0;
    end else begin
      out_flush <= mispredict;
      if (mispredict && (out_mispredict_count != {CNT_WIDTH{1'b1}}))
        out_mispredict_count <= out_mispredict_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios followed by
// randomized traffic, all compared against an arithmetic reference model.
module tb_branch_predictor;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        lookup_valid;
  logic [63:0] lookup_pc;
  logic        prediction;
  logic        pred_valid;
  logic        update_valid;
  logic [63:0] update_pc;
  logic        update_taken;
  logic        update_predicted;
  logic        flush;
  logic [15:0] mispredict_count;

  branch_predictor #(.INDEX_BITS(6), .PC_WIDTH(64), .CNT_WIDTH(16)) dut (
    .in_clk              (clk),
    .in_rst              (rst),
    .in_stall            (stall),
    .in_lookup_valid     (lookup_valid),
    .in_lookup_pc        (lookup_pc),
    .out_prediction      (prediction),
    .out_pred_valid      (pred_valid),
    .in_update_valid     (update_valid),
    .in_update_pc        (update_pc),
    .in_update_taken     (update_taken),
    .in_update_predicted (update_predicted),
    .out_flush           (flush),
    .out_mispredict_count(mispredict_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: counters as integers 0..3, outputs as plain values.
  int tab [64];
  int m_count;
  bit m_pred, m_valid, m_flush;
  int total = 0;
  int passes = 0;
  int fails = 0;

  function automatic int idx_of(input logic [63:0] pc);
    return int'((pc >> 2) % 64);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) tab[i] = 1;
    m_count = 0; m_pred = 0; m_valid = 0; m_flush = 0;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".pred"},  {63'd0, prediction}, {63'd0, m_pred});
    chk({tag, ".valid"}, {63'd0, pred_valid}, {63'd0, m_valid});
    chk({tag, ".flush"}, {63'd0, flush},      {63'd0, m_flush});
    chk({tag, ".count"}, {48'd0, mispredict_count}, 64'(m_count));
  endtask

  // One clock of stimulus; inputs change 1 time unit after the active edge.
  task automatic step(input bit s, input bit lv, input logic [63:0] lpc,
                      input bit uv, input logic [63:0] upc, input bit ut, input bit up,
                      input bit do_chk, input string tag);
    stall = s; lookup_valid = lv; lookup_pc = lpc;
    update_valid = uv; update_pc = upc; update_taken = ut; update_predicted = up;
    @(posedge clk);
    if (uv) begin
      int k = idx_of(upc);
      tab[k] = ut ? ((tab[k] + 1 > 3) ? 3 : tab[k] + 1) : ((tab[k] - 1 < 0) ? 0 : tab[k] - 1);
    end
    m_flush = uv && (ut != up);
    if (m_flush && m_count < 65535) m_count++;
    if (!s) begin
      m_valid = lv;
      m_pred  = lv ? (tab[idx_of(lpc)] >= 2) : 1'b0;
    end
    #1;
    if (do_chk) begin
      chk_all(tag);
      $display("%s: stall=%0d lv=%0d lpc=%0h uv=%0d upc=%0h t=%0d p=%0d -> pred=%0d valid=%0d flush=%0d count=%0d",
               tag, s, lv, lpc, uv, upc, ut, up, prediction, pred_valid, flush, mispredict_count);
    end
  endtask

  // Raise reset mid-cycle (checks that it acts without a clock edge), hold
  // it across an edge, then release it away from the edge.
  task automatic do_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk_all({tag, ".async"});
    @(posedge clk); #1;
    chk_all({tag, ".held"});
    stall = 0; lookup_valid = 0; update_valid = 0; update_taken = 0; update_predicted = 0;
    lookup_pc = '0; update_pc = '0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    stall = 0; lookup_valid = 0; lookup_pc = '0;
    update_valid = 0; update_pc = '0; update_taken = 0; update_predicted = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset");
    rst = 1'b0;

    // Basic lookup after reset.
    step(0, 1, 64'h1000, 0, 0, 0, 0, 1, "lookup_1000");

    // Two mispredicted taken updates: 01 -> 10 -> 11, flush on both.
    step(0, 0, 0, 1, 64'h1000, 1, 0, 1, "train_1000_a");
    step(0, 0, 0, 1, 64'h1000, 1, 0, 1, "train_1000_b");
    step(0, 1, 64'h1000, 0, 0, 0, 0, 1, "lookup_1000_taken");

    // Saturation at 0x2040.
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 64'h2040, 1, 1, 1, "sat_taken");
    step(0, 0, 0, 1, 64'h2040, 0, 1, 1, "sat_nt_1");
    step(0, 1, 64'h2040, 0, 0, 0, 0, 1, "sat_lookup_1");
    step(0, 0, 0, 1, 64'h2040, 0, 1, 1, "sat_nt_2");
    step(0, 1, 64'h2040, 0, 0, 0, 0, 1, "sat_lookup_2");

    // Bypass and aliasing from a fresh table.
    do_reset("rst_bypass");
    step(0, 1, 64'h3000, 1, 64'h3000, 1, 0, 1, "bypass_3000");
    step(0, 1, 64'h3100, 1, 64'h3100, 1, 0, 1, "bypass_alias_3100");
    step(0, 1, 64'h3004, 0, 0, 0, 0, 1, "other_idx_3004");
    step(0, 1, 64'h3000, 0, 0, 0, 0, 1, "alias_3000");
    step(0, 1, 64'h3004, 1, 64'h3000, 0, 1, 1, "diff_idx_indep");

    // Stall holds outputs while updates keep training and flushing.
    step(0, 1, 64'h3000, 0, 0, 0, 0, 1, "pre_stall");
    step(1, 1, 64'h3004, 1, 64'h3004, 1, 0, 1, "stall_1");
    step(1, 0, 64'h3008, 1, 64'h3004, 1, 0, 1, "stall_2");
    step(1, 1, 64'h300c, 0, 0, 0, 0, 1, "stall_3");
    step(0, 1, 64'h3004, 0, 0, 0, 0, 1, "post_stall");

    // Reset asserted during a mispredict update cycle.
    stall = 0; lookup_valid = 0; update_valid = 1; update_pc = 64'h3004;
    update_taken = 0; update_predicted = 1;
    do_reset("rst_midflush");
    for (int i = 0; i < 64; i++)
      step(0, 1, 64'(i * 4) | 64'hABC0_0000_0000_0000, 0, 0, 0, 0, 1, "post_reset_idx");

    // Randomized traffic over a few hot indices to force collisions.
    for (int i = 0; i < 300; i++) begin
      logic [63:0] lpc, upc;
      lpc = {$urandom, $urandom};
      upc = {$urandom, $urandom};
      lpc[7:2] = 6'($urandom_range(0, 3));
      upc[7:2] = ($urandom_range(0, 1) == 1) ? lpc[7:2] : 6'($urandom_range(0, 3));
      step(($urandom_range(0, 3) == 0), 1'($urandom), lpc,
           1'($urandom), upc, 1'($urandom), 1'($urandom), 1, "random");
    end

    // Misprediction counter saturation.
    do_reset("rst_sat");
    for (int i = 0; i < 65534; i++)
      step(0, 0, 0, 1, {$urandom, $urandom}, 1, 0, 0, "bulk");
    step(0, 0, 0, 1, 64'h4000, 0, 1, 1, "count_ffff");
    step(0, 0, 0, 1, 64'h4000, 1, 0, 1, "count_stays_ffff");
    step(0, 0, 0, 0, 0, 0, 0, 1, "flush_drop");

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
